// File: rtl/instr_loader.sv
// Byte-serial program loader for the instruction memory.
// Packs framed bytes MSB-first into words and writes them out.
module instr_loader #(
  parameter int unsigned ADDR_W     = 6,
  parameter logic [7:0]  START_BYTE = 8'hA5,
  parameter logic [7:0]  END_BYTE   = 8'h5A,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   load_count_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [8:0] MAX_N = 9'(2**ADDR_W);
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, TAIL, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_q;
  logic [23:0]       word_q;
  logic [1:0]        idx_q;
  logic [TW-1:0]     tmo_q;

  logic busy_st;
  logic tmo_hit;
  logic len_bad;
  logic last_word;
  logic is_start;
  logic is_end;

  // Byte classification and timeout expiry decode
  always_comb begin
    busy_st   = (state_q == LEN) || (state_q == DATA) ||
                (state_q == TAIL);
    tmo_hit   = busy_st && !byte_valid_i &&
                (tmo_q == TW'(TIMEOUT - 1));
    len_bad   = (byte_i == 8'd0) || ({1'b0, byte_i} > MAX_N);
    last_word = (load_count_o + CNT_ONE) == n_q;
    is_start  = byte_i == START_BYTE;
    is_end    = byte_i == END_BYTE;
  end

  // Next-state logic; a byte in the expiry cycle beats the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (byte_valid_i && is_start)
          state_d = LEN;
      end
      LEN: begin
        if (byte_valid_i)
          state_d = len_bad ? ERR : DATA;
        else if (tmo_hit)
          state_d = ERR;
      end
      DATA: begin
        if (byte_valid_i) begin
          if (idx_q == 2'd3 && last_word)
            state_d = TAIL;
        end else if (tmo_hit) begin
          state_d = ERR;
        end
      end
      TAIL: begin
        if (byte_valid_i)
          state_d = is_end ? IDLE : ERR;
        else if (tmo_hit)
          state_d = ERR;
      end
      ERR: begin
        if (byte_valid_i && is_start)
          state_d = LEN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Word assembly, write port, counters and status flags
  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      load_count_o <= '0;
      n_q          <= '0;
      word_q       <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
    end else begin
      busy_o  <= (state_d == LEN) || (state_d == DATA) ||
                 (state_d == TAIL);
      err_o   <= state_d == ERR;
      done_o  <= (state_q == TAIL) && byte_valid_i && is_end;
      wr_en_o <= (state_q == DATA) && byte_valid_i &&
                 (idx_q == 2'd3);

      if (busy_st && !byte_valid_i)
        tmo_q <= tmo_q + TW'(1);
      else
        tmo_q <= '0;

      if (state_q == LEN && byte_valid_i && !len_bad) begin
        n_q          <= byte_i[ADDR_W:0];
        wr_addr_o    <= '0;
        idx_q        <= '0;
        load_count_o <= '0;
      end

      if (state_q == DATA && byte_valid_i) begin
        word_q <= {word_q[15:0], byte_i};
        idx_q  <= idx_q + 2'd1;
        if (idx_q == 2'd3)
          wr_data_o <= {word_q, byte_i};
      end

      // The last word keeps its address so it never wraps
      if (wr_en_o) begin
        load_count_o <= load_count_o + CNT_ONE;
        if (!last_word)
          wr_addr_o <= wr_addr_o + ADDR_W'(1);
      end
    end
  end

endmodule
